aes256_key_expansion: RTL and testbench

// - Upstream feeder of the AES-256 decrypt datapath.
// - Expands a 256-bit cipher key into 15 round keys (60 x 32-bit words), one word per cycle, into an internal key store.
// - Serves round keys to the decrypt core through a combinational read port addressed by round_key_addr.
// - Asserts round_key_rdy once the full schedule is valid. The decrypt core counts rounds only while round_key_rdy=1.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_sub_word.sv | 14 +
 rtl/aes256_key_expansion.sv | 144 ++++++++++++++
 tb/tb_aes256_key_expansion.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: schedule constants, Rcon table and the forward S-box.
// The S-box is computed as GF(2^8) inverse followed by the affine map.
package aes_pkg;

    localparam int NB         = 4;
    localparam int NK         = 8;
    localparam int NR         = 14;
    localparam int ROUND_KEYS = 15;
    localparam int WORDS      = 60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } kexp_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    // Byte-wise substitution
    always_comb begin
        result = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes256_key_expansion.sv
// AES-256 key schedule: one word per cycle into a 60x32 store, combinational round-key read.
// Optional AES_KEYEXP_ZEROIZE_EN clears the store on reset and on every key load.
module aes256_key_expansion
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 256
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [3:0]            round_key_addr,
    output logic [DATA_WIDTH-1:0] round_key,
    output logic                  round_key_rdy,
    output logic                  busy
);

    kexp_state_e state_r;
    kexp_state_e state_s;
    logic [5:0]  cnt_r;
    logic [31:0] w_r [0:WORDS-1];
    logic        load_s;
    logic        step_s;
    logic        last_s;
    logic [5:0]  prev_idx_s;
    logic [5:0]  old_idx_s;
    logic [31:0] prev_s;
    logic [31:0] old_s;
    logic [31:0] sub_in_s;
    logic [31:0] sub_out_s;
    logic [31:0] new_word_s;

    // Next-state and control decode; En while expanding is deliberately ignored
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_READY: begin
                if (En) begin
                    load_s  = 1'b1;
                    state_s = ST_EXPAND;
                end else begin
                    state_s = state_r;
                end
            end
            ST_EXPAND: begin
                step_s = 1'b1;
                if (cnt_r == 6'd59) begin
                    last_s  = 1'b1;
                    state_s = ST_READY;
                end else begin
                    state_s = ST_EXPAND;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next schedule word from w[i-1] and w[i-8]; indices clamped when not expanding
    always_comb begin
        prev_idx_s = (cnt_r >= 6'd8) ? (cnt_r - 6'd1) : 6'd7;
        old_idx_s  = (cnt_r >= 6'd8) ? (cnt_r - 6'd8) : 6'd0;
        prev_s     = w_r[prev_idx_s];
        old_s      = w_r[old_idx_s];
        sub_in_s   = (cnt_r[2:0] == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        case (cnt_r[2:0])
            3'd0:    new_word_s = old_s ^ sub_out_s ^ {rcon(cnt_r[5:3]), 24'h000000};
            3'd4:    new_word_s = old_s ^ sub_out_s;
            default: new_word_s = old_s ^ prev_s;
        endcase
    end

    aes_sub_word u_sub_word (
        .word   (sub_in_s),
        .result (sub_out_s)
    );

    // FSM state, word counter and registered status flags
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 6'd0;
            round_key_rdy <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                cnt_r         <= 6'd8;
                round_key_rdy <= 1'b0;
                busy          <= 1'b1;
            end else if (last_s) begin
                round_key_rdy <= 1'b1;
                busy          <= 1'b0;
            end else if (step_s) begin
                cnt_r <= cnt_r + 6'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef AES_KEYEXP_ZEROIZE_EN
    // Key store with clear on reset and on load so no stale key material survives
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < WORDS; k++) begin
                w_r[k] <= 32'h0000_0000;
            end
        end else if (load_s) begin
            for (int k = 0; k < WORDS; k++) begin
                w_r[k] <= (k < NK) ? key_in[KEY_WIDTH-1-32*k -: 32] : 32'h0000_0000;
            end
        end else if (step_s) begin
            w_r[cnt_r] <= new_word_s;
        end
    end
`else
    // Key store without reset: only the cipher key words and schedule words are written
    always_ff @(posedge Clk) begin
        if (load_s) begin
            for (int k = 0; k < NK; k++) begin
                w_r[k] <= key_in[KEY_WIDTH-1-32*k -: 32];
            end
        end else if (step_s) begin
            w_r[cnt_r] <= new_word_s;
        end
    end
`endif

    // Round-key read port; address 15 is out of range and reads zero
    always_comb begin
        round_key = {DATA_WIDTH{1'b0}};
        if (round_key_addr != 4'd15) begin
            round_key = {w_r[{round_key_addr, 2'b00}], w_r[{round_key_addr, 2'b01}],
                         w_r[{round_key_addr, 2'b10}], w_r[{round_key_addr, 2'b11}]};
        end else begin
            round_key = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_aes256_key_expansion.sv
// Randomized self-checking bench for aes256_key_expansion against a table-driven key-schedule model.
module tb_aes256_key_expansion;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         En;
    logic [255:0] key_in;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key;
    logic         round_key_rdy;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // model state
    logic [1919:0] m_words = '0;
    logic [255:0]  m_key   = '0;
    logic          m_rdy   = 1'b0;
    logic          m_busy  = 1'b0;
    int            m_left  = 0;

    aes256_key_expansion dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .En             (En),
        .key_in         (key_in),
        .round_key_addr (round_key_addr),
        .round_key      (round_key),
        .round_key_rdy  (round_key_rdy),
        .busy           (busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sbox_tbl[2047 - 8 * int'(x[8*b +: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] res;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) t = sub_word({t[23:0], t[31:24]}) ^ ((32'h01 << (i/8 - 1)) << 24);
            else if (i % 8 == 4) t = sub_word(t);
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) res[1919 - 32*i -: 32] = w[i];
        return res;
    endfunction

    function automatic logic [127:0] model_rk(input logic [1919:0] ws, input int r);
        if (r >= 15) return 128'h0;
        return ws[1919 - 128*r -: 128];
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        round_key_addr = 4'($urandom_range(0, 15));
    endtask

    // Cycle-level timing model: 52 schedule words follow the load edge
    always @(posedge Clk) begin
        if (Rst) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
            m_left <= 0;
`ifdef AES_KEYEXP_ZEROIZE_EN
            m_words <= '0;
`endif
        end else if (En && !m_busy) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b1;
            m_left <= 52;
            m_key  <= key_in;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_rdy   <= 1'b1;
                m_words <= expand(m_key);
            end
            m_left <= m_left - 1;
        end
    end

    // Every-cycle comparison of status flags and, when ready, the addressed round key
    always @(negedge Clk) begin
        if (chk_en) begin
            check("rdy", {127'h0, round_key_rdy}, {127'h0, m_rdy});
            check("busy", {127'h0, busy}, {127'h0, m_busy});
            if (m_rdy) check("round_key", round_key, model_rk(m_words, int'(round_key_addr)));
        end
    end

    task automatic load_and_wait(input logic [255:0] k, output int n);
        key_in = k;
        En     = 1'b1;
        tick();
        En     = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n = 1;
        while (!round_key_rdy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_rk(input logic [3:0] a, input string name, input logic [127:0] exp);
        round_key_addr = a;
        #1;
        check(name, round_key, exp);
    endtask

    initial begin
        int n;
        logic [255:0] k2;
        logic [255:0] fips_key;
        logic [1919:0] fips_ws;
        fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        Rst = 1'b1;
        En = 1'b0;
        key_in = '0;
        round_key_addr = 4'd0;
        repeat (3) tick();
        check("reset_rdy", {127'h0, round_key_rdy}, 128'h0);
        check("reset_busy", {127'h0, busy}, 128'h0);
        Rst = 1'b0;
        chk_en = 1'b1;

        // pin the model with FIPS-197 values
        fips_ws = expand(fips_key);
        check("model_rk2", model_rk(fips_ws, 2), 128'ha573c29fa176c498a97fce93a572c09c);
        check("model_rk14", model_rk(fips_ws, 14), 128'h24fc79ccbf0979e9371ac23c6d68de36);

        load_and_wait(fips_key, n);
        check("latency", n, 53);
        read_rk(4'd0, "fips_rk0", 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(4'd1, "fips_rk1", 128'h101112131415161718191a1b1c1d1e1f);
        read_rk(4'd2, "fips_rk2", 128'ha573c29fa176c498a97fce93a572c09c);
        read_rk(4'd14, "fips_rk14", 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(4'd15, "addr15", 128'h0);

        // En pulsed mid-expansion must be ignored
        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_in = k2;
        En = 1'b1;
        tick();
        En = 1'b0;
        repeat (19) tick();
        key_in = ~k2;
        En = 1'b1;
        tick();
        En = 1'b0;
        n = 21;
        while (!round_key_rdy && n < 200) begin
            tick();
            n++;
        end
        check("ignore_latency", n, 53);
        read_rk(4'd14, "ignore_rk14", model_rk(expand(k2), 14));
        read_rk(4'd7, "ignore_rk7", model_rk(expand(k2), 7));

        // restart from READY with an all-zero key
        key_in = '0;
        En = 1'b1;
        tick();
        En = 1'b0;
        check("restart_rdy_drop", {127'h0, round_key_rdy}, 128'h0);
        n = 1;
        while (!round_key_rdy && n < 200) begin
            tick();
            n++;
        end
        check("zero_latency", n, 53);
        read_rk(4'd0, "zero_rk0", 128'h0);
        read_rk(4'd14, "zero_rk14", model_rk(expand(256'h0), 14));

        // a few random keys
        for (int j = 0; j < 3; j++) begin
            load_and_wait({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, n);
            check("rand_latency", n, 53);
            repeat (8) tick();
        end

        // En held as a level keeps restarting once ready
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        En = 1'b1;
        repeat (70) tick();
        En = 1'b0;
        repeat (60) tick();

        // reset mid-expansion aborts it
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        En = 1'b1;
        tick();
        En = 1'b0;
        repeat (29) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("abort_rdy", {127'h0, round_key_rdy}, 128'h0);
        check("abort_busy", {127'h0, busy}, 128'h0);
`ifdef AES_KEYEXP_ZEROIZE_EN
        for (int a = 0; a < 16; a++) read_rk(4'(a), "zeroize_rk", 128'h0);
`endif
        repeat (60) tick();
        check("abort_stays_idle", {127'h0, round_key_rdy}, 128'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
